// File: rtl/count_zeros_select_if.sv
// count_zeros_select_if
// Request/response bundle for the zero-select unit.
//   pass    : request strobe (master -> slave), taken only while ready is high
//   x       : word to search (master -> slave)
//   k       : 0-based index of the zero to locate (master -> slave)
//   ready   : unit idle and able to accept a request (slave -> master)
//   valid_r : one-cycle result pulse (slave -> master)
//   found_r : a (k+1)-th zero exists (slave -> master)
//   pos_r   : bit position of the located zero, 0 when not found (slave -> master)
interface count_zeros_select_if #(
  parameter int W = 32
);
  localparam int LW = $clog2(W);

  logic          pass;
  logic [W-1:0]  x;
  logic [LW-1:0] k;
  logic          ready;
  logic          valid_r;
  logic          found_r;
  logic [LW-1:0] pos_r;

  modport master (
    output pass, x, k,
    input  ready, valid_r, found_r, pos_r
  );

  modport slave (
    input  pass, x, k,
    output ready, valid_r, found_r, pos_r
  );
endinterface

// File: rtl/count_zeros_select.sv
// count_zeros_select
// Iterative select on zero bits: returns the position of the (k+1)-th zero of
// a W-bit word, counting from the LSB. One nibble is examined per cycle while
// a running remainder tracks how many zeros are still to be skipped.
//   clk : clock
//   rst : synchronous, active-high reset
//   bus : count_zeros_select_if slave port (pass/x/k in, ready/valid_r/found_r/pos_r out)
module count_zeros_select #(
  parameter int W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  count_zeros_select_if.slave  bus
);

  localparam int N  = W / 4;
  localparam int LW = $clog2(W);
  localparam int IW = $clog2(N);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  word_q, word_d;
  logic [LW-1:0] rem_q, rem_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          valid_q, valid_d;
  logic          found_q, found_d;
  logic [LW-1:0] pos_q, pos_d;

  logic [3:0]    nib;
  logic [2:0]    nib_zeros;
  logic [1:0]    nib_offset;

  // Number of zero bits in a nibble (0..4).
  function automatic logic [2:0] zero_count(input logic [3:0] n);
    zero_count = {2'b00, ~n[0]} + {2'b00, ~n[1]} + {2'b00, ~n[2]} + {2'b00, ~n[3]};
  endfunction

  // Position inside the nibble of the r-th zero (LSB first). Only meaningful
  // when the nibble holds more than r zeros, so r never exceeds 3 here.
  function automatic logic [1:0] zero_offset(input logic [3:0] n, input logic [1:0] r);
    logic [2:0] seen;
    logic       hit;
    zero_offset = 2'd0;
    seen        = 3'd0;
    hit         = 1'b0;
    for (int b = 0; b < 4; b++) begin
      if (!n[b]) begin
        if (!hit && seen == {1'b0, r}) begin
          zero_offset = b[1:0];
          hit         = 1'b1;
        end
        seen = seen + 3'd1;
      end
    end
  endfunction

  // Nibble currently under inspection and its lookups.
  always_comb begin
    nib        = word_q[idx_q*4 +: 4];
    nib_zeros  = zero_count(nib);
    nib_offset = zero_offset(nib, rem_q[1:0]);
  end

  // Next-state and datapath logic. A request is taken only in IDLE; SCAN
  // either resolves in the current nibble, gives up on the last nibble, or
  // consumes the nibble's zeros from the remainder and moves on.
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    rem_d   = rem_q;
    idx_d   = idx_q;
    valid_d = 1'b0;
    found_d = found_q;
    pos_d   = pos_q;

    case (state_q)
      IDLE: begin
        if (bus.pass) begin
          word_d  = bus.x;
          rem_d   = bus.k;
          idx_d   = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (rem_q < LW'(nib_zeros)) begin
          found_d = 1'b1;
          pos_d   = LW'({idx_q, 2'b00}) + LW'(nib_offset);
          valid_d = 1'b1;
          state_d = DONE;
        end else if (idx_q == IW'(N - 1)) begin
          found_d = 1'b0;
          pos_d   = '0;
          valid_d = 1'b1;
          state_d = DONE;
        end else begin
          rem_d = rem_q - LW'(nib_zeros);
          idx_d = idx_q + IW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and result registers; reset abandons any search in flight and
  // suppresses a pending result pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      word_q  <= '0;
      rem_q   <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      found_q <= 1'b0;
      pos_q   <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      rem_q   <= rem_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      found_q <= found_d;
      pos_q   <= pos_d;
    end
  end

  assign bus.ready   = (state_q == IDLE);
  assign bus.valid_r = valid_q;
  assign bus.found_r = found_q;
  assign bus.pos_r   = pos_q;

endmodule

// File: tb/tb_count_zeros_select.sv
// tb_count_zeros_select
// Scoreboard bench for count_zeros_select: the driver pushes the reference
// result and expected pulse cycle for each accepted request, a monitor pops
// and compares whenever valid_r is seen.
module tb_count_zeros_select;

  localparam int W = 32;

  typedef struct {
    bit found;
    int pos;
    int cycle;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   errors;
  bit   expect_ready;
  exp_t sb[$];

  count_zeros_select_if #(.W(W)) bus();

  count_zeros_select #(.W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Single comparison point: counts every check and reports mismatches.
  task automatic check_output(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Reference: walk the bits LSB first counting zeros.
  function automatic void ref_select(input logic [31:0] xv, input int kv,
                                     output bit f, output int p);
    int cnt;
    cnt = 0;
    f   = 0;
    p   = 0;
    for (int i = 0; i < W; i++) begin
      if (!xv[i]) begin
        if (!f && cnt == kv) begin
          f = 1;
          p = i;
        end
        cnt++;
      end
    end
  endfunction

  // Issue one request from a negedge; returns at the negedge after acceptance
  // with the inputs scrambled to prove they are not re-sampled.
  task automatic apply_stimulus(input logic [31:0] xv, input logic [4:0] kv);
    exp_t e;
    int   n;
    int   guard;
    guard = 0;
    while (!bus.ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!bus.ready) begin
      errors++;
      $display("[TB] FAIL ready_timeout: ready=%0b, expected 1", bus.ready);
    end
    ref_select(xv, int'(kv), e.found, e.pos);
    n       = e.found ? e.pos / 4 : (W / 4 - 1);
    e.cycle = cyc + 1 + n + 1;
    sb.push_back(e);
    bus.pass = 1'b1;
    bus.x    = xv;
    bus.k    = kv;
    @(negedge clk);
    bus.pass = 1'b0;
    bus.x    = $urandom;
    bus.k    = 5'($urandom);
  endtask

  // Wait until the unit is idle and all expected results have been seen.
  task automatic wait_idle();
    int guard;
    guard = 0;
    while ((!bus.ready || sb.size() != 0) && guard < 60) begin
      @(negedge clk);
      guard++;
    end
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL result_timeout: %0d results outstanding, expected 0", sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  // Monitor: compares each result pulse against the scoreboard head and
  // checks that ready comes back the cycle after the pulse.
  always @(negedge clk) begin
    if (!rst) begin
      if (expect_ready) begin
        check_output("ready_after_valid", int'(bus.ready), 1);
        expect_ready = 0;
      end
      if (bus.valid_r) begin
        if (sb.size() == 0) begin
          errors++;
          $display("[TB] FAIL unexpected_valid: valid_r=1, expected 0 (cycle %0d)", cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check_output("found_r", int'(bus.found_r), int'(e.found));
          check_output("pos_r", int'(bus.pos_r), e.pos);
          check_output("valid_cycle", cyc, e.cycle);
          check_output("ready_during_valid", int'(bus.ready), 0);
          expect_ready = 1;
        end
      end
    end
  end

  initial begin
    int guard;
    cyc          = 0;
    checks       = 0;
    errors       = 0;
    expect_ready = 0;
    rst          = 1'b1;
    bus.pass     = 1'b1;
    bus.x        = 32'h0;
    bus.k        = 5'd0;
    @(negedge clk);
    @(negedge clk);
    rst      = 1'b0;
    bus.pass = 1'b0;

    check_output("reset_valid", int'(bus.valid_r), 0);
    check_output("reset_found", int'(bus.found_r), 0);
    check_output("reset_pos", int'(bus.pos_r), 0);
    check_output("reset_ready", int'(bus.ready), 1);

    // Directed cases.
    apply_stimulus(32'hFFFF_FFFE, 5'd0);  wait_idle();
    apply_stimulus(32'h0000_0000, 5'd31); wait_idle();
    apply_stimulus(32'h0000_0000, 5'd4);  wait_idle();
    apply_stimulus(32'hFFFF_FFFF, 5'd0);  wait_idle();
    apply_stimulus(32'h7FFF_FFFF, 5'd0);  wait_idle();
    apply_stimulus(32'h7FFF_FFFF, 5'd1);  wait_idle();
    apply_stimulus(32'hAAAA_AAAA, 5'd5);  wait_idle();
    apply_stimulus(32'h0F0F_0F0F, 5'd9);  wait_idle();

    // Requests while busy are ignored; a request on the ready cycle works.
    apply_stimulus(32'h1234_5678, 5'd7);
    guard = 0;
    while (!bus.ready && guard < 50) begin
      bus.pass = 1'b1;
      bus.x    = $urandom;
      bus.k    = 5'($urandom);
      @(negedge clk);
      guard++;
    end
    bus.pass = 1'b0;
    apply_stimulus(32'hF0F0_F0F0, 5'd3);
    wait_idle();

    // Reset during the third SCAN cycle abandons the search.
    apply_stimulus(32'h0000_0000, 5'd31);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    sb.delete();
    expect_ready = 0;
    @(negedge clk);
    rst = 1'b0;
    check_output("midscan_rst_found", int'(bus.found_r), 0);
    check_output("midscan_rst_pos", int'(bus.pos_r), 0);
    check_output("midscan_rst_ready", int'(bus.ready), 1);
    check_output("midscan_rst_valid", int'(bus.valid_r), 0);
    repeat (10) @(negedge clk);
    apply_stimulus(32'hFFFF_FFF7, 5'd0);
    wait_idle();

    // Randomized requests, biased towards sparse-zero words for not-found hits.
    for (int i = 0; i < 60; i++) begin
      logic [31:0] xv;
      xv = $urandom;
      if (i % 3 == 0) xv = xv | $urandom;
      if (i % 5 == 0) xv = xv & $urandom;
      apply_stimulus(xv, 5'($urandom));
      if (i % 2 == 0) wait_idle();
    end
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
